// File: rtl/iir_ctrl.sv
// iir_ctrl: streaming controller wrapped around an external biquad IIR datapath.
//
// Accepts samples on a valid/ready input, hands them to the filter (filt_x/filt_en),
// tracks the filter's fixed latency with a valid shift register, and captures filt_y
// into an output FIFO that drains over a valid/ready output. Coefficients are written
// into shadow registers at any time and applied atomically by a commit: the controller
// stops accepting input, waits for in-flight samples to land, copies shadow to active,
// then pulses filt_clr for one cycle before resuming.
//
// Ports:
//   clk, rst (sync, active-low)
//   s_valid/s_ready/s_data       input sample stream
//   m_valid/m_ready/m_data       filtered output stream (FIFO head)
//   cfg_we/cfg_addr/cfg_wdata    shadow coefficient write (0=b0 1=b1 2=b2 3=a1 4=a2)
//   cfg_commit                   apply shadow coefficients (honoured only in RUN)
//   busy                         high while a commit is in progress
//   sample_cnt                   accepted-sample counter (wraps)
//   filt_x/filt_en/filt_clr      filter drive
//   filt_b0..filt_a2             active coefficients
//   filt_y                       filter output, valid LAT cycles after filt_en
module iir_ctrl #(
  parameter int unsigned        LAT    = 1,
  parameter int unsigned        DEPTH  = 4,
  parameter logic signed [15:0] B0_RST = 16'sd16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [15:0] m_data,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_addr,
  input  logic signed [15:0] cfg_wdata,
  input  logic               cfg_commit,
  output logic               busy,
  output logic [15:0]        sample_cnt,
  output logic signed [15:0] filt_x,
  output logic               filt_en,
  output logic               filt_clr,
  output logic signed [15:0] filt_b0,
  output logic signed [15:0] filt_b1,
  output logic signed [15:0] filt_b2,
  output logic signed [15:0] filt_a1,
  output logic signed [15:0] filt_a2,
  input  logic signed [15:0] filt_y
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StLoad, StClear} state_e;

  state_e state_q, state_d;

  logic [LAT-1:0]     vld_q, vld_d;
  logic [CW-1:0]      inflight;
  logic [CW:0]        occupancy;

  logic signed [15:0] mem_q [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [CW-1:0]      fifo_cnt_q, fifo_cnt_d;
  logic               push, pop;

  logic signed [15:0] shadow_q [5];
  logic signed [15:0] active_q [5];
  logic [15:0]        sample_cnt_q;

  // ---------------------------------------------------------------------------
  // Input side
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < LAT; i++) begin
      inflight = inflight + CW'(vld_q[i]);
    end
  end

  // Everything accepted but not yet popped counts against FIFO space, so a
  // sample is only taken when its eventual slot is guaranteed.
  assign occupancy = {1'b0, fifo_cnt_q} + {1'b0, inflight};

  assign s_ready = rst && (state_q == StRun) && (occupancy < DepthW);
  assign filt_en = s_valid && s_ready;
  assign filt_x  = filt_en ? s_data : 16'sd0;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = filt_en;
    for (int unsigned i = 1; i < LAT; i++) begin
      vld_d[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q        <= '0;
      sample_cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      if (filt_en) sample_cnt_q <= sample_cnt_q + 16'd1;
    end
  end

  assign sample_cnt = sample_cnt_q;

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  assign push    = vld_q[LAT-1];
  assign m_valid = rst && (fifo_cnt_q != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = mem_q[rptr_q];

  always_comb begin
    fifo_cnt_d = fifo_cnt_q;
    if (push && !pop) begin
      fifo_cnt_d = fifo_cnt_q + CW'(1);
    end else if (!push && pop) begin
      fifo_cnt_d = fifo_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= filt_y;
  end

  // ---------------------------------------------------------------------------
  // Coefficients
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 5; i++) begin
        shadow_q[i] <= (i == 0) ? B0_RST : 16'sd0;
        active_q[i] <= (i == 0) ? B0_RST : 16'sd0;
      end
    end else begin
      if (cfg_we) begin
        case (cfg_addr)
          3'd0:    shadow_q[0] <= cfg_wdata;
          3'd1:    shadow_q[1] <= cfg_wdata;
          3'd2:    shadow_q[2] <= cfg_wdata;
          3'd3:    shadow_q[3] <= cfg_wdata;
          3'd4:    shadow_q[4] <= cfg_wdata;
          default: ;
        endcase
      end
      // LOAD sees the shadow as of the previous edge, so a write in the commit
      // cycle is already in place.
      if (state_q == StLoad) begin
        for (int i = 0; i < 5; i++) active_q[i] <= shadow_q[i];
      end
    end
  end

  assign filt_b0 = active_q[0];
  assign filt_b1 = active_q[1];
  assign filt_b2 = active_q[2];
  assign filt_a1 = active_q[3];
  assign filt_a2 = active_q[4];

  // ---------------------------------------------------------------------------
  // Commit sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (cfg_commit) state_d = StDrain;
      StDrain: if (inflight == '0) state_d = StLoad;
      StLoad:  state_d = StClear;
      StClear: state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy     = rst && (state_q != StRun);
  assign filt_clr = !rst || (state_q == StClear);

endmodule

// File: tb/tb_iir_ctrl.sv
// Bench for iir_ctrl with a stub filter y = (b0 * x) >>> 14 delayed LAT cycles.
module tb_iir_ctrl;

  localparam int LAT   = 1;
  localparam int DEPTH = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               m_valid;
  logic               m_ready;
  logic signed [15:0] m_data;
  logic               cfg_we;
  logic [2:0]         cfg_addr;
  logic signed [15:0] cfg_wdata;
  logic               cfg_commit;
  logic               busy;
  logic [15:0]        sample_cnt;
  logic signed [15:0] filt_x;
  logic               filt_en;
  logic               filt_clr;
  logic signed [15:0] filt_b0, filt_b1, filt_b2, filt_a1, filt_a2;
  logic signed [15:0] filt_y;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  iir_ctrl #(
    .LAT    (LAT),
    .DEPTH  (DEPTH),
    .B0_RST (16'sd16384)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_wdata  (cfg_wdata),
    .cfg_commit (cfg_commit),
    .busy       (busy),
    .sample_cnt (sample_cnt),
    .filt_x     (filt_x),
    .filt_en    (filt_en),
    .filt_clr   (filt_clr),
    .filt_b0    (filt_b0),
    .filt_b1    (filt_b1),
    .filt_b2    (filt_b2),
    .filt_a1    (filt_a1),
    .filt_a2    (filt_a2),
    .filt_y     (filt_y)
  );

  always #5 clk = ~clk;

  // Stub filter
  logic signed [31:0] prod;
  logic signed [31:0] prod_sh;
  logic signed [15:0] pipe [LAT];
  assign prod    = 32'(filt_b0) * 32'(filt_x);
  assign prod_sh = prod >>> 14;
  always_ff @(posedge clk) begin
    if (filt_clr) begin
      for (int i = 0; i < LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= prod_sh[15:0];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign filt_y = pipe[LAT-1];

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    s_valid = 0; s_data = 0; m_ready = 0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 0;
    tick();
    tick();
    rst = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0; s_valid = 1; s_data = 16'sd5; cfg_commit = 1;
    tick();
    #1;
    checks++; if (filt_clr !== 1'b1) begin errors++; $display("FAIL rst_filt_clr got=%b want=1", filt_clr); end
    checks++; if (filt_en !== 1'b0) begin errors++; $display("FAIL rst_filt_en got=%b want=0", filt_en); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b want=0", s_ready); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b want=0", m_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy); end
    tick();
    rst = 1; idle_inputs();
    #1;
    checks++; if (filt_b0 !== 16'sd16384) begin errors++; $display("FAIL rst_b0 got=%0d want=16384", filt_b0); end
    checks++;
    if ({filt_b1, filt_b2, filt_a1, filt_a2} !== 64'd0) begin
      errors++; $display("FAIL rst_coef got=%0d,%0d,%0d,%0d want=0,0,0,0", filt_b1, filt_b2, filt_a1, filt_a2);
    end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL rst_cnt got=%0d want=0", sample_cnt); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after got=%b want=1", s_ready); end
    checks++; if (busy !== 1'b0 || filt_clr !== 1'b0) begin errors++; $display("FAIL rst_after busy=%b clr=%b want=0,0", busy, filt_clr); end
  endtask

  task automatic test_passthrough();
    logic signed [15:0] vals [4];
    int acc_cyc [4];
    int ni = 0;
    int no = 0;
    vals[0] = 16'sd1; vals[1] = 16'sd2; vals[2] = 16'sd3; vals[3] = -16'sd4;
    idle_inputs();
    m_ready = 1;
    for (int k = 0; k < 30 && no < 4; k++) begin
      s_valid = (ni < 4);
      s_data  = (ni < 4) ? vals[ni] : 16'sd0;
      #1;
      if (m_valid) begin
        checks++;
        if (no >= ni) begin
          errors++; $display("FAIL pt_spurious got=%0d want=no output", m_data);
        end else begin
          if (m_data !== vals[no]) begin errors++; $display("FAIL pt_data[%0d] got=%0d want=%0d", no, m_data, vals[no]); end
          checks++;
          if (cyc - acc_cyc[no] != 2) begin errors++; $display("FAIL pt_latency[%0d] got=%0d want=2", no, cyc - acc_cyc[no]); end
        end
        no++;
      end
      if (s_valid && s_ready) begin
        checks++;
        if (filt_x !== s_data || filt_en !== 1'b1) begin
          errors++; $display("FAIL pt_filt_x got=%0d en=%b want=%0d en=1", filt_x, filt_en, s_data);
        end
        acc_cyc[ni] = cyc;
        ni++;
      end
      tick();
    end
    s_valid = 0;
    #1;
    checks++; if (no != 4) begin errors++; $display("FAIL pt_count got=%0d want=4", no); end
    checks++; if (sample_cnt !== 16'd4) begin errors++; $display("FAIL pt_sample_cnt got=%0d want=4", sample_cnt); end
    checks++; if (filt_en !== 1'b0 || filt_x !== 16'sd0) begin errors++; $display("FAIL pt_idle_filt got en=%b x=%0d want 0,0", filt_en, filt_x); end
  endtask

  task automatic test_backpressure();
    logic signed [15:0] exp_q [$];
    logic signed [15:0] held;
    logic signed [15:0] want;
    int n_acc = 0;
    idle_inputs();
    s_valid = 1;
    for (int k = 0; k < 12; k++) begin
      s_data = 16'(300 + k);
      #1;
      if (s_valid && s_ready) begin exp_q.push_back(s_data); n_acc++; end
      tick();
    end
    #1;
    checks++; if (n_acc != DEPTH) begin errors++; $display("FAIL bp_transfers got=%0d want=%0d", n_acc, DEPTH); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b want=0", s_ready); end
    held = m_data;
    tick();
    checks++;
    if (m_valid !== 1'b1 || m_data !== held || m_data !== 16'sd300) begin
      errors++; $display("FAIL bp_hold got v=%b d=%0d want v=1 d=300", m_valid, m_data);
    end
    s_valid = 0; m_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      if (m_valid) begin
        want = exp_q.pop_front();
        checks++; if (m_data !== want) begin errors++; $display("FAIL bp_order got=%0d want=%0d", m_data, want); end
      end
      tick();
    end
    #1;
    checks++; if (exp_q.size() != 0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL bp_drain got left=%0d m_valid=%b want 0,0", exp_q.size(), m_valid);
    end
  endtask

  task automatic test_commit_inflight();
    int nouts = 0;
    int clr_cycles = 0;
    bit sent = 0;
    idle_inputs();
    m_ready = 1;
    cfg_we = 1; cfg_addr = 3'd0; cfg_wdata = 16'sd8192;
    tick();
    cfg_we = 0;
    s_valid = 1; s_data = 16'sd200; cfg_commit = 1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL ci_ready_commit got=%b want=1", s_ready); end
    tick();
    cfg_commit = 0;
    for (int k = 0; k < 20 && nouts < 2; k++) begin
      s_valid = !sent; s_data = 16'sd100;
      #1;
      if (k == 0) begin
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin
          errors++; $display("FAIL ci_drain got busy=%b ready=%b want 1,0", busy, s_ready);
        end
        checks++; if (filt_b0 !== 16'sd16384) begin errors++; $display("FAIL ci_b0_early got=%0d want=16384", filt_b0); end
      end
      checks++; if (busy && s_ready) begin errors++; $display("FAIL ci_ready_busy got=1 want=0"); end
      if (filt_clr) begin
        clr_cycles++;
        checks++; if (filt_b0 !== 16'sd8192) begin errors++; $display("FAIL ci_b0_at_clr got=%0d want=8192", filt_b0); end
      end
      if (m_valid) begin
        checks++;
        if (nouts == 0 && m_data !== 16'sd200) begin errors++; $display("FAIL ci_old_out got=%0d want=200", m_data); end
        if (nouts == 1 && m_data !== 16'sd50) begin errors++; $display("FAIL ci_new_out got=%0d want=50", m_data); end
        nouts++;
      end
      if (s_valid && s_ready) begin
        sent = 1;
        checks++; if (clr_cycles == 0) begin errors++; $display("FAIL ci_early_accept got=before clr want=after clr"); end
      end
      tick();
    end
    s_valid = 0;
    checks++; if (clr_cycles != 1) begin errors++; $display("FAIL ci_clr_pulse got=%0d want=1", clr_cycles); end
    checks++; if (nouts != 2) begin errors++; $display("FAIL ci_outputs got=%0d want=2", nouts); end
  endtask

  task automatic test_cfg_simul();
    idle_inputs();
    m_ready = 1;
    cfg_we = 1; cfg_addr = 3'd3; cfg_wdata = 16'sh1234; cfg_commit = 1;
    tick();
    cfg_we = 0; cfg_commit = 0;
    #1;
    checks++; if (busy !== 1'b1 || filt_a1 !== 16'sd0) begin
      errors++; $display("FAIL cs_drain got busy=%b a1=%h want 1,0000", busy, filt_a1);
    end
    for (int k = 0; k < 10 && busy; k++) tick();
    checks++; if (busy !== 1'b0 || filt_a1 !== 16'sh1234) begin
      errors++; $display("FAIL cs_a1 got busy=%b a1=%h want 0,1234", busy, filt_a1);
    end
    cfg_we = 1; cfg_addr = 3'd6; cfg_wdata = 16'sh7777; cfg_commit = 1;
    tick();
    cfg_we = 0;
    for (int k = 0; k < 10 && busy; k++) begin
      cfg_commit = 1;
      tick();
    end
    cfg_commit = 0;
    checks++;
    if (filt_b0 !== 16'sd8192 || filt_b1 !== 16'sd0 || filt_b2 !== 16'sd0 ||
        filt_a1 !== 16'sh1234 || filt_a2 !== 16'sd0) begin
      errors++; $display("FAIL cs_addr6 got=%h,%h,%h,%h,%h want=2000,0000,0000,1234,0000",
                         filt_b0, filt_b1, filt_b2, filt_a1, filt_a2);
    end
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cs_no_queue got busy=%b want=0", busy); end
      tick();
    end
  endtask

  task automatic test_reset_drain();
    idle_inputs();
    cfg_we = 1; cfg_addr = 3'd0; cfg_wdata = 16'sd4000;
    tick();
    cfg_we = 0;
    s_valid = 1; s_data = 16'sd77; cfg_commit = 1;
    #1;
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rd_accept got=%b want=1", s_ready); end
    tick();
    s_valid = 0; cfg_commit = 0;
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rd_in_drain got=%b want=1", busy); end
    rst = 0;
    tick();
    rst = 1;
    #1;
    checks++; if (busy !== 1'b0 || m_valid !== 1'b0) begin
      errors++; $display("FAIL rd_state got busy=%b m_valid=%b want 0,0", busy, m_valid);
    end
    checks++; if (filt_b0 !== 16'sd16384) begin errors++; $display("FAIL rd_b0 got=%0d want=16384", filt_b0); end
    checks++; if (sample_cnt !== 16'd0) begin errors++; $display("FAIL rd_cnt got=%0d want=0", sample_cnt); end
    m_ready = 1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rd_no_output cyc%0d got=1 want=0", k); end
    end
  endtask

  task automatic test_random();
    logic signed [15:0] exp_q [$];
    logic signed [15:0] want;
    logic [15:0] cnt_exp = 16'd0;
    bit acc;
    apply_reset();
    for (int k = 0; k < 600; k++) begin
      s_valid = ($urandom % 4) != 0;
      m_ready = ($urandom % 3) != 0;
      s_data  = 16'($urandom);
      #1;
      checks++;
      if (s_ready !== (exp_q.size() < DEPTH)) begin
        errors++; $display("FAIL rnd_ready cyc%0d got=%b want=%b", k, s_ready, exp_q.size() < DEPTH);
      end
      acc = s_valid && s_ready;
      if (m_valid === 1'b1 && exp_q.size() == 0) begin
        checks++; errors++; $display("FAIL rnd_spurious cyc%0d got=%0d want=empty", k, m_data);
      end else if (m_valid && m_ready) begin
        want = exp_q.pop_front();
        checks++; if (m_data !== want) begin errors++; $display("FAIL rnd_data cyc%0d got=%0d want=%0d", k, m_data, want); end
      end
      if (acc) begin exp_q.push_back(s_data); cnt_exp++; end
      tick();
    end
    s_valid = 0; m_ready = 1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
      #1;
      if (m_valid) begin
        want = exp_q.pop_front();
        checks++; if (m_data !== want) begin errors++; $display("FAIL rnd_tail got=%0d want=%0d", m_data, want); end
      end
      tick();
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rnd_lost got=%0d left want=0", exp_q.size()); end
    checks++; if (sample_cnt !== cnt_exp) begin errors++; $display("FAIL rnd_cnt got=%0d want=%0d", sample_cnt, cnt_exp); end
  endtask

  task automatic test_wrap();
    int n = 0;
    apply_reset();
    s_valid = 1; m_ready = 1;
    for (int k = 0; k < 70000 && n < 65537; k++) begin
      s_data = 16'($urandom);
      #1;
      if (s_valid && s_ready) n++;
      tick();
    end
    s_valid = 0;
    #1;
    checks++; if (n != 65537) begin errors++; $display("FAIL wrap_transfers got=%0d want=65537", n); end
    checks++; if (sample_cnt !== 16'd1) begin errors++; $display("FAIL wrap_cnt got=%0d want=1", sample_cnt); end
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_passthrough();
    test_backpressure();
    test_commit_inflight();
    test_cfg_simul();
    test_reset_drain();
    test_random();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
